// File: rtl/vga_fb_arbiter.sv
// Frame-buffer RAM arbiter: per-line prefetch FIFO with 2x scanout doubling, leftover slots to a pixel writer.
// Optional sticky starvation flag built only when VGA_FB_UNDERRUN_EN is defined.
module vga_fb_arbiter #(
  parameter int unsigned H_RES      = 320,
  parameter int unsigned V_RES      = 240,
  parameter int unsigned DATA_W     = 12,
  parameter int unsigned ADDR_W     = 17,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned H_TRIG     = 656
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  input  logic [10:0]       x,
  input  logic [10:0]       y,
  output logic [DATA_W-1:0] pix_rgb,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ack,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              underrun
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned REM_W   = $clog2(H_RES + 1);
  localparam int unsigned FB_SIZE = H_RES * V_RES;
  localparam logic [10:0] X_ACT   = 11'd640;
  localparam logic [10:0] Y_ACT   = 11'd480;
  localparam logic [10:0] Y_LAST  = 11'd524;
  localparam logic [10:0] X_TRIG  = 11'(H_TRIG);

  typedef enum logic {IDLE, FETCH} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   fetch_addr_q, fetch_addr_d;
  logic [REM_W-1:0]    remaining_q, remaining_d;
  logic                inflight_q, inflight_d;
  logic                drop_q, drop_d;
  logic                run_q;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [DATA_W-1:0]   fifo_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]   pix_rgb_q, pix_rgb_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic                ram_we_q, ram_we_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;

  logic [10:0]         ly;
  logic [CNT_W:0]      occupancy;
  logic                restart, active, fifo_empty, rd_issue, wr_issue, push, pop;
  logic [DATA_W-1:0]   head;

  // Request decode shared by arbitration, FIFO and scanout
  always_comb begin
    ly         = (y == Y_LAST) ? 11'd0 : y + 11'd1;
    restart    = pix_en && (x == X_TRIG) && (ly < Y_ACT);
    active     = pix_en && (x < X_ACT) && (y < Y_ACT);
    fifo_empty = (count_q == '0);
    occupancy  = {1'b0, count_q} + (CNT_W+1)'(inflight_q);
    rd_issue   = (state_q == FETCH) && (occupancy < (CNT_W+1)'(FIFO_DEPTH));
    wr_issue   = run_q && !rd_issue && wr_req;
    push       = inflight_q && !drop_q && !restart;
    pop        = active && x[0] && !fifo_empty && !restart;
    head       = fifo_mem[rd_ptr_q];
  end

  // Next-state: fetch FSM, RAM port, FIFO pointers, scanout pixel
  always_comb begin
    state_d      = state_q;
    fetch_addr_d = fetch_addr_q;
    remaining_d  = remaining_q;
    inflight_d   = rd_issue;
    drop_d       = restart && rd_issue;
    ram_addr_d   = ram_addr_q;
    ram_we_d     = 1'b0;
    ram_wdata_d  = ram_wdata_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    pix_rgb_d    = pix_rgb_q;

    if (rd_issue) begin
      ram_addr_d   = fetch_addr_q;
      fetch_addr_d = fetch_addr_q + ADDR_W'(1);
      remaining_d  = remaining_q - REM_W'(1);
      if (remaining_q == REM_W'(1)) state_d = IDLE;
    end else if (wr_issue) begin
      ram_addr_d  = wr_addr;
      ram_wdata_d = wr_data;
      ram_we_d    = (wr_addr < ADDR_W'(FB_SIZE));
    end

    // A new line start discards everything queued or in flight for the old one
    if (restart) begin
      fetch_addr_d = ADDR_W'(ly >> 1) * ADDR_W'(H_RES);
      remaining_d  = REM_W'(H_RES);
      state_d      = FETCH;
      rd_ptr_d     = '0;
      wr_ptr_d     = '0;
      count_d      = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    if (pix_en) pix_rgb_d = (active && !fifo_empty) ? head : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      fetch_addr_q <= '0;
      remaining_q  <= '0;
      inflight_q   <= 1'b0;
      drop_q       <= 1'b0;
      run_q        <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      pix_rgb_q    <= '0;
      ram_addr_q   <= '0;
      ram_we_q     <= 1'b0;
      ram_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      fetch_addr_q <= fetch_addr_d;
      remaining_q  <= remaining_d;
      inflight_q   <= inflight_d;
      drop_q       <= drop_d;
      run_q        <= 1'b1;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      pix_rgb_q    <= pix_rgb_d;
      ram_addr_q   <= ram_addr_d;
      ram_we_q     <= ram_we_d;
      ram_wdata_q  <= ram_wdata_d;
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= ram_rdata;
  end

`ifdef VGA_FB_UNDERRUN_EN
  logic underrun_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    underrun_q <= 1'b0;
    else if (active && fifo_empty) underrun_q <= 1'b1;
  end

  assign underrun = underrun_q;
`else
  assign underrun = 1'b0;
`endif

  // Ack is combinational so the writer can stream one pixel per free slot
  assign wr_ack    = wr_issue;
  assign pix_rgb   = pix_rgb_q;
  assign ram_addr  = ram_addr_q;
  assign ram_we    = ram_we_q;
  assign ram_wdata = ram_wdata_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: line table with hand-computed pixels plus writer, starvation,
// retrigger and reset sequences. Expected underrun follows VGA_FB_UNDERRUN_EN.
module tb_vga_fb_arbiter;

  localparam int unsigned FB_N = 76800;

`ifdef VGA_FB_UNDERRUN_EN
  localparam logic EXP_UR = 1'b1;
`else
  localparam logic EXP_UR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pix_en;
  logic [10:0] x, y;
  logic [11:0] pix_rgb;
  logic        wr_req;
  logic [16:0] wr_addr;
  logic [11:0] wr_data;
  logic        wr_ack;
  logic [16:0] ram_addr;
  logic        ram_we;
  logic [11:0] ram_wdata;
  logic [11:0] ram_rdata;
  logic        underrun;

  logic [11:0] fb [FB_N];
  logic        fill_req;
  logic [11:0] line_buf [640];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned wr_next = 1000;
  int          n_acks;
  int          max_wait;
  logic        stop_wr;

  typedef struct {
    logic [10:0] ty;
    logic [10:0] dy;
    logic        wr;
    logic [11:0] e0, e1, e2, e639;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  vga_fb_arbiter dut (
    .clk(clk), .rst_n(rst_n), .pix_en(pix_en), .x(x), .y(y), .pix_rgb(pix_rgb),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .underrun(underrun)
  );

  // Frame buffer: combinational read of the registered address, write on the edge
  assign ram_rdata = (ram_addr < 17'(FB_N)) ? fb[ram_addr] : 12'd0;

  always @(posedge clk) begin
    if (fill_req) begin
      for (int i = 0; i < int'(FB_N); i++) fb[i] <= 12'(i);
    end else if (ram_we && ram_addr < 17'(FB_N)) begin
      fb[ram_addr] <= ram_wdata;
    end
  end

  function automatic vec_t mk(input int ty, input int dy, input int wr,
                              input int e0, input int e1, input int e2, input int e639);
    vec_t v;
    v.ty = 11'(ty); v.dy = 11'(dy); v.wr = 1'(wr);
    v.e0 = 12'(e0); v.e1 = 12'(e1); v.e2 = 12'(e2); v.e639 = 12'(e639);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // One pixel tick: pix_en for one clk, then three idle clks
  task automatic tick(input logic [10:0] xx, input logic [10:0] yy, output logic [11:0] rgb);
    @(negedge clk);
    x = xx; y = yy; pix_en = 1'b1;
    @(negedge clk);
    pix_en = 1'b0;
    rgb = pix_rgb;
    repeat (2) @(negedge clk);
  endtask

  // Blanking from the trigger tick, then the active part of the displayed line
  task automatic run_line(input logic [10:0] ty, input logic [10:0] dy);
    logic [11:0] rgb, e;
    int nmis;
    tick(11'd656, ty, rgb);
    for (int xi = 657; xi < 800; xi++) tick(11'(xi), ty, rgb);
    nmis = 0;
    for (int xi = 0; xi < 640; xi++) begin
      tick(11'(xi), dy, rgb);
      line_buf[xi] = rgb;
      e = (dy < 11'd480) ? 12'(32'(dy >> 1) * 320 + xi / 2) : 12'd0;
      if (rgb !== e) nmis++;
    end
    chk("line_full_mismatches", 32'(nmis), 32'd0);
  endtask

  // Streams writes of unchanged pixel values; checks each acked write on the RAM port
  task automatic writer_run();
    int unsigned a_prev = 0;
    logic pend = 1'b0;
    int waitc = 0;
    max_wait = 0;
    @(negedge clk);
    while (!stop_wr) begin
      if (pend) begin
        chk("wr_ram_addr", 32'(ram_addr), a_prev);
        chk("wr_ram_wdata", 32'(ram_wdata), 32'(12'(a_prev)));
        chk("wr_ram_we", 32'(ram_we), 32'd1);
        pend = 1'b0;
      end
      wr_req = 1'b1; wr_addr = 17'(wr_next); wr_data = 12'(wr_next);
      #1;
      if (wr_ack) begin
        pend = 1'b1; a_prev = wr_next; wr_next++; n_acks++; waitc = 0;
      end else begin
        waitc++;
        if (waitc > max_wait) max_wait = waitc;
      end
      @(negedge clk);
    end
    if (pend) begin
      chk("wr_ram_addr", 32'(ram_addr), a_prev);
      chk("wr_ram_we", 32'(ram_we), 32'd1);
    end
    wr_req = 1'b0;
  endtask

  initial begin
    logic [11:0] rgb;
    rst_n = 1'b0; pix_en = 1'b0; x = '0; y = '0;
    wr_req = 1'b0; wr_addr = '0; wr_data = '0; stop_wr = 1'b0; fill_req = 1'b1;

    vecs[0] = mk(524,   0, 0,    0,    0,    1,  319);
    vecs[1] = mk(  0,   1, 0,    0,    0,    1,  319);
    vecs[2] = mk(  1,   2, 0,  320,  320,  321,  639);
    vecs[3] = mk(  2,   3, 1,  320,  320,  321,  639);
    vecs[4] = mk(100, 101, 0, 3712, 3712, 3713, 4031);
    vecs[5] = mk(478, 479, 1, 2752, 2752, 2753, 3071);
    vecs[6] = mk(479, 480, 0,    0,    0,    0,    0);

    #1;
    chk("rst_pix_rgb", 32'(pix_rgb), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    @(posedge clk); #1 fill_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].wr) begin
        stop_wr = 1'b0; n_acks = 0;
        fork
          begin run_line(vecs[i].ty, vecs[i].dy); stop_wr = 1'b1; end
          writer_run();
        join
        chk("wr_ack_count_gt_100", 32'(n_acks > 100), 32'd1);
        chk("wr_max_wait", 32'(max_wait), 32'd8);
      end else begin
        run_line(vecs[i].ty, vecs[i].dy);
      end
      chk("px_x0", 32'(line_buf[0]), 32'(vecs[i].e0));
      chk("px_x1", 32'(line_buf[1]), 32'(vecs[i].e1));
      chk("px_x2", 32'(line_buf[2]), 32'(vecs[i].e2));
      chk("px_x639", 32'(line_buf[639]), 32'(vecs[i].e639));
    end
    chk("no_underrun_normal", 32'(underrun), 32'd0);

    // Out-of-range write is acked but not written; last valid address is written
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 17'd76800; wr_data = 12'hABC;
    #1 chk("oor_wr_ack", 32'(wr_ack), 32'd1);
    @(negedge clk);
    chk("oor_ram_we", 32'(ram_we), 32'd0);
    chk("oor_ram_addr", 32'(ram_addr), 32'd76800);
    wr_addr = 17'd76799; wr_data = 12'hBFF;
    #1 chk("last_wr_ack", 32'(wr_ack), 32'd1);
    @(negedge clk);
    chk("last_ram_we", 32'(ram_we), 32'd1);
    chk("last_ram_wdata", 32'(ram_wdata), 32'hBFF);
    wr_req = 1'b0;

    // Retrigger four clks into the prefill: old line 5 returns must not appear
    tick(11'd656, 11'd10, rgb);
    run_line(11'd20, 11'd21);
    chk("retrig_px_x0", 32'(line_buf[0]), 32'd3200);
    chk("retrig_px_x639", 32'(line_buf[639]), 32'd3519);

    // Active ticks with no prefetch: FIFO empty throughout
    for (int xi = 0; xi < 10; xi++) begin
      tick(11'(xi), 11'd10, rgb);
      chk("starve_px", 32'(rgb), 32'd0);
    end
    chk("starve_underrun", 32'(underrun), 32'(EXP_UR));

    // Asynchronous reset in the middle of an active line
    tick(11'd656, 11'd30, rgb);
    for (int xi = 657; xi < 800; xi++) tick(11'(xi), 11'd30, rgb);
    for (int xi = 0; xi < 100; xi++) tick(11'(xi), 11'd31, rgb);
    chk("pre_reset_px", 32'(rgb), 32'd753);
    @(negedge clk);
    wr_req = 1'b1; wr_addr = 17'd5; wr_data = 12'd5;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_pix_rgb", 32'(pix_rgb), 32'd0);
    chk("mid_rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("mid_rst_ram_we", 32'(ram_we), 32'd0);
    chk("mid_rst_ram_wdata", 32'(ram_wdata), 32'd0);
    chk("mid_rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("mid_rst_underrun", 32'(underrun), 32'd0);
    wr_req = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    run_line(11'd40, 11'd41);
    chk("post_rst_px_x0", 32'(line_buf[0]), 32'd2304);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
